player_motion: RTL and testbench
================================

# player_motion

Per-player motion engine between the controller block and `vga_bitchange`. It consumes the 7-bit debounced controller vector and advances a grounded/airborne state machine on an internally divided movement tick. It drives the registered `player_x`/`player_y` position the renderer draws, plus pose and facing. It replaces the free-running top-level movement `always` block with a resettable, clamped, gravity-based model.

## Interface
Parameters:
- `TICK_DIV`, 714_285: `clk` cycles per movement tick (~70 Hz at 50 MHz); must be ≥ 2.
- `X_START`, 300: reset x.
- `GROUND_Y`, 300: reset and landing y.
- `X_MIN`, 0 / `X_MAX`, 600: inclusive x clamp.
- `Y_MIN`, 20: inclusive upper-screen clamp.
- `SPEED`, 2: horizontal pixels per tick.
- `JUMP_VEL`, 12: takeoff velocity, 1..31; also the fall-speed cap.

Ports:
- `clk`  in  1  system clock; every register is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `controller_inputs`  in  7  bit1 left, bit2 right, bit3 up, bit4 down, bit5 attack, bit6 shield (all active-high); bit0 unused.
- `player_x`  out  10  horizontal position.
- `player_y`  out  10  vertical position; smaller values are higher on screen.
- `pose`  out  3  0 IDLE, 1 WALK, 2 CROUCH, 3 BLOCK, 4 RISE, 5 FALL.
- `facing_left`  out  1  1 = sprite faces left.
- `airborne`  out  1  high in RISE or FALL.
- `move_tick`  out  1  one-cycle pulse on the cycle after each state update.

## Operation
- Tick counter runs 0..TICK_DIV-1 and wraps. The update strobe fires when the counter = TICK_DIV-1.
- Inputs are sampled only on the strobe cycle and have no effect between strobes.
- Grounded states (IDLE/WALK/CROUCH/BLOCK) use this priority on each strobe:
  - Up → RISE. Set vy=JUMP_VEL. Latch air direction: left-only = -1, right-only = +1, otherwise 0. y does not change on the takeoff tick.
  - Down → CROUCH. No x change.
  - Shield → BLOCK. No x change.
  - Exactly one of left/right → WALK. x ±SPEED, clamped to [X_MIN, X_MAX]. `facing_left` updates.
  - Otherwise (including left+right together) → IDLE.
- RISE strobe:
  - If y < Y_MIN+vy: y=Y_MIN, vy=0, go to FALL.
  - Otherwise: y -= vy, then vy -= 1. When vy was 1, go to FALL with vy=0.
- FALL strobe:
  - vy_n = min(vy+1, JUMP_VEL).
  - If y+vy_n ≥ GROUND_Y: y=GROUND_Y, vy=0, go to IDLE. This is the landing.
  - Otherwise: y += vy_n, vy = vy_n.
- Horizontal motion in the air, on every RISE/FALL strobe: x += dir×SPEED, clamped to [X_MIN, X_MAX].
- Attack (bit5) is ignored by this block. Up, down and shield are ignored while airborne.
- Arithmetic uses 11-bit intermediates so the clamps never wrap. vy is 5 bits unsigned.

## Timing
- Reset values: player_x=X_START, player_y=GROUND_Y, pose=IDLE, facing_left=0, airborne=0, move_tick=0, counter=0, vy=0, dir=0.
- Position, pose and airborne are registered and update the cycle after the strobe. `move_tick` pulses in that same cycle.
- First strobe after reset release is at cycle TICK_DIV-1.
- `rst` mid-jump returns to ground on the next edge and restarts the counter. No partial arc resumes.
- With defaults, a jump is 1 takeoff tick + 12 rise ticks (apex at GROUND_Y-78) + 12 fall ticks. Landing occurs on tick 24 after takeoff.

## Configuration
- `PLAYER_AIR_CONTROL_EN` defined: on each airborne strobe, dir is re-evaluated from left/right (left-only -1, right-only +1, otherwise 0) and `facing_left` follows it.
- Undefined: dir stays as latched at takeoff for the whole jump, and `facing_left` is frozen while airborne.

## Test plan
Bench uses TICK_DIV=4.
- Reset, no input for 10 strobes → x=300, y=300, pose IDLE, `move_tick` every 4 cycles.
- Right held 3 strobes → x=306, pose WALK, facing_left=0. Then left+right held → x stays 306, pose IDLE.
- Up for 1 strobe from ground, then released:
  - y=300 at takeoff, 288 after rise tick 1, 222 after tick 12 (pose FALL).
  - y=300 and pose IDLE after tick 24; airborne high throughout ticks 0..23.
- X clamp: start x=3, left held → x=1, then X_MIN (0) held while pose stays WALK.
- Y clamp: GROUND_Y=50, Y_MIN=20, jump → y clamps to 20, pose FALL, then lands at 50.
- Air control: up+right at takeoff, then left-only in the air:
  - With `PLAYER_AIR_CONTROL_EN`: x decreases 2/tick and facing_left=1.
  - Without it: x increases 2/tick.
  - Assert `rst` at tick 5 → y=300, pose IDLE next cycle.

Source files
------------

// File: rtl/player_motion.sv
// player_motion: per-player grounded/airborne motion engine.
// Consumes the debounced controller vector and, on a divided movement
// tick, updates position, pose and facing for the renderer.
// Optional feature macro: PLAYER_AIR_CONTROL_EN (steer left/right while airborne).
module player_motion #(
    parameter int unsigned TICK_DIV = 714_285,
    parameter int unsigned X_START  = 300,
    parameter int unsigned GROUND_Y = 300,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 600,
    parameter int unsigned Y_MIN    = 20,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned JUMP_VEL = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] controller_inputs,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [2:0] pose,
    output logic       facing_left,
    output logic       airborne,
    output logic       move_tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned PW = 10;
    localparam int unsigned AW = 11;
    localparam int unsigned VW = 5;

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] X_MIN_W  = AW'(X_MIN);
    localparam logic [AW-1:0] X_MAX_W  = AW'(X_MAX);
    localparam logic [AW-1:0] Y_MIN_W  = AW'(Y_MIN);
    localparam logic [AW-1:0] GROUND_W = AW'(GROUND_Y);
    localparam logic [AW-1:0] SPEED_W  = AW'(SPEED);
    localparam logic [VW-1:0] JV_W     = VW'(JUMP_VEL);

    // Horizontal direction encoding: {left, right}
    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WALK   = 3'd1,
        S_CROUCH = 3'd2,
        S_BLOCK  = 3'd3,
        S_RISE   = 3'd4,
        S_FALL   = 3'd5
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [PW-1:0] x_q, x_d;
    logic [PW-1:0] y_q, y_d;
    logic [VW-1:0] vy_q, vy_d;
    logic [1:0]    dir_q, dir_d;
    logic          fl_q, fl_d;
    logic          air_q, air_d;
    logic          tick_q, tick_d;

    logic          strobe;
    logic          btn_left, btn_right, btn_up, btn_down, btn_shield;
    logic [1:0]    lr_dir;
    logic [1:0]    air_dir;
    logic [AW-1:0] x_ext, x_left, x_right;
    logic [AW-1:0] y_ext, vy_ext, vy_n_ext;
    logic [VW-1:0] vy_n;
    logic          rise_hit, fall_land;
    logic          ctrl_unused;

    assign btn_left    = controller_inputs[1];
    assign btn_right   = controller_inputs[2];
    assign btn_up      = controller_inputs[3];
    assign btn_down    = controller_inputs[4];
    assign btn_shield  = controller_inputs[6];
    assign ctrl_unused = controller_inputs[0] ^ controller_inputs[5];

    assign strobe = (cnt_q == CNT_LAST);
    assign lr_dir = {btn_left & ~btn_right, btn_right & ~btn_left};

`ifdef PLAYER_AIR_CONTROL_EN
    assign air_dir = lr_dir;
`else
    assign air_dir = dir_q;
`endif

    // Clamped horizontal candidates and vertical step arithmetic (11-bit, no wrap)
    always_comb begin
        x_ext    = {1'b0, x_q};
        y_ext    = {1'b0, y_q};
        vy_ext   = AW'(vy_q);
        x_left   = (x_ext < X_MIN_W + SPEED_W) ? X_MIN_W : x_ext - SPEED_W;
        x_right  = (x_ext + SPEED_W > X_MAX_W) ? X_MAX_W : x_ext + SPEED_W;
        vy_n     = (vy_q >= JV_W) ? JV_W : vy_q + VW'(1);
        vy_n_ext = AW'(vy_n);
        rise_hit  = (y_ext < Y_MIN_W + vy_ext);
        fall_land = (y_ext + vy_n_ext >= GROUND_W);
    end

    // Next-state and datapath update, applied only on the movement strobe
    always_comb begin
        cnt_d   = strobe ? '0 : cnt_q + CW'(1);
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        dir_d   = dir_q;
        fl_d    = fl_q;
        tick_d  = strobe;

        if (strobe) begin
            unique case (state_q)
                S_RISE, S_FALL: begin
                    dir_d = air_dir;
`ifdef PLAYER_AIR_CONTROL_EN
                    if (air_dir == DIR_LEFT)  fl_d = 1'b1;
                    if (air_dir == DIR_RIGHT) fl_d = 1'b0;
`endif
                    if (air_dir == DIR_LEFT)  x_d = PW'(x_left);
                    if (air_dir == DIR_RIGHT) x_d = PW'(x_right);

                    if (state_q == S_RISE) begin
                        if (rise_hit) begin
                            y_d     = PW'(Y_MIN_W);
                            vy_d    = '0;
                            state_d = S_FALL;
                        end else begin
                            y_d  = PW'(y_ext - vy_ext);
                            vy_d = vy_q - VW'(1);
                            if (vy_q == VW'(1)) state_d = S_FALL;
                        end
                    end else begin
                        if (fall_land) begin
                            y_d     = PW'(GROUND_W);
                            vy_d    = '0;
                            state_d = S_IDLE;
                        end else begin
                            y_d  = PW'(y_ext + vy_n_ext);
                            vy_d = vy_n;
                        end
                    end
                end
                default: begin
                    if (btn_up) begin
                        state_d = S_RISE;
                        vy_d    = JV_W;
                        dir_d   = lr_dir;
                    end else if (btn_down) begin
                        state_d = S_CROUCH;
                    end else if (btn_shield) begin
                        state_d = S_BLOCK;
                    end else if (lr_dir == DIR_LEFT) begin
                        state_d = S_WALK;
                        x_d     = PW'(x_left);
                        fl_d    = 1'b1;
                    end else if (lr_dir == DIR_RIGHT) begin
                        state_d = S_WALK;
                        x_d     = PW'(x_right);
                        fl_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end

        air_d = (state_d == S_RISE) || (state_d == S_FALL);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            x_q     <= PW'(X_START);
            y_q     <= PW'(GROUND_Y);
            vy_q    <= '0;
            dir_q   <= DIR_NONE;
            fl_q    <= 1'b0;
            air_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            dir_q   <= dir_d;
            fl_q    <= fl_d;
            air_q   <= air_d;
            tick_q  <= tick_d;
        end
    end

    assign player_x    = x_q;
    assign player_y    = y_q;
    assign pose        = state_q;
    assign facing_left = fl_q;
    assign airborne    = air_q;
    assign move_tick   = tick_q;

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: scoreboard bench for player_motion.
// Three instances (default, X_START=3, GROUND_Y=50) share clock, reset and
// controller input; a behavioural model predicts each strobe's outcome.
// Honours PLAYER_AIR_CONTROL_EN in the same way as the design.
module tb_player_motion;

    localparam int TD = 4;

    typedef struct packed {
        int   x;
        int   y;
        int   vy;
        int   dir;
        int   pose;
        logic fl;
    } mst_t;
    typedef mst_t [2:0] trio_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] ctrl = 7'd0;

    logic [9:0] px [3];
    logic [9:0] py [3];
    logic [2:0] ps [3];
    logic       fl [3];
    logic       air[3];
    logic       mt [3];

    int    n_chk  = 0;
    int    n_fail = 0;
    trio_t exp_q[$];
    trio_t mdl;
    trio_t mon_e;
    int    cyc     = 0;
    int    last_mt = -1;

    always #5 clk = ~clk;

    player_motion #(.TICK_DIV(TD)) u_dut0 (
        .clk(clk), .rst(rst), .controller_inputs(ctrl),
        .player_x(px[0]), .player_y(py[0]), .pose(ps[0]),
        .facing_left(fl[0]), .airborne(air[0]), .move_tick(mt[0]));

    player_motion #(.TICK_DIV(TD), .X_START(3)) u_dut1 (
        .clk(clk), .rst(rst), .controller_inputs(ctrl),
        .player_x(px[1]), .player_y(py[1]), .pose(ps[1]),
        .facing_left(fl[1]), .airborne(air[1]), .move_tick(mt[1]));

    player_motion #(.TICK_DIV(TD), .GROUND_Y(50)) u_dut2 (
        .clk(clk), .rst(rst), .controller_inputs(ctrl),
        .player_x(px[2]), .player_y(py[2]), .pose(ps[2]),
        .facing_left(fl[2]), .airborne(air[2]), .move_tick(mt[2]));

    function automatic int xs_of(input int i);
        return (i == 1) ? 3 : 300;
    endfunction

    function automatic int gy_of(input int i);
        return (i == 2) ? 50 : 300;
    endfunction

    function automatic int clampx(input int v);
        return (v < 0) ? 0 : ((v > 600) ? 600 : v);
    endfunction

    // Reference: one movement tick of the motion rules (pose 0..3 grounded, 4 rise, 5 fall)
    function automatic mst_t step(input mst_t s, input logic [6:0] c, input int gy);
        mst_t n;
        int   lr;
        int   v;
        n  = s;
        lr = (c[1] && !c[2]) ? -1 : ((c[2] && !c[1]) ? 1 : 0);
        if (s.pose < 4) begin
            if (c[3]) begin
                n.pose = 4; n.vy = 12; n.dir = lr;
            end else if (c[4]) begin
                n.pose = 2;
            end else if (c[6]) begin
                n.pose = 3;
            end else if (lr != 0) begin
                n.pose = 1; n.x = clampx(s.x + 2 * lr); n.fl = (lr < 0);
            end else begin
                n.pose = 0;
            end
        end else begin
`ifdef PLAYER_AIR_CONTROL_EN
            n.dir = lr;
            if (lr != 0) n.fl = (lr < 0);
`endif
            n.x = clampx(s.x + 2 * n.dir);
            if (s.pose == 4) begin
                if (s.y - s.vy < 20) begin
                    n.y = 20; n.vy = 0; n.pose = 5;
                end else begin
                    n.y = s.y - s.vy; n.vy = s.vy - 1;
                    if (n.vy == 0) n.pose = 5;
                end
            end else begin
                v = (s.vy + 1 > 12) ? 12 : s.vy + 1;
                if (s.y + v >= gy) begin
                    n.y = gy; n.vy = 0; n.pose = 0;
                end else begin
                    n.y = s.y + v; n.vy = v;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ctrl = 7'd0;
        exp_q.delete();
        slot();
        for (int i = 0; i < 3; i++) begin
            mdl[i] = '{x: xs_of(i), y: gy_of(i), vy: 0, dir: 0, pose: 0, fl: 1'b0};
            chk($sformatf("rst_x%0d", i), int'(px[i]), xs_of(i));
            chk($sformatf("rst_y%0d", i), int'(py[i]), gy_of(i));
            chk($sformatf("rst_pose%0d", i), int'(ps[i]), 0);
            chk($sformatf("rst_face%0d", i), int'(fl[i]), 0);
            chk($sformatf("rst_air%0d", i), int'(air[i]), 0);
            chk($sformatf("rst_tick%0d", i), int'(mt[i]), 0);
        end
        rst = 1'b0;
    endtask

    // Issue one tick period of input and queue the predicted outcome
    task automatic tick(input logic [6:0] c);
        ctrl = c;
        for (int i = 0; i < 3; i++) mdl[i] = step(mdl[i], c, gy_of(i));
        exp_q.push_back(mdl);
        repeat (TD) slot();
    endtask

    // Monitor: on each move_tick pop the prediction and compare every instance
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_mt = -1;
        end else if (mt[0]) begin
            if (last_mt >= 0) chk("tick_period", cyc - last_mt, TD);
            last_mt = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("sb_tick%0d", i), int'(mt[i]), 1);
                    chk($sformatf("sb_x%0d", i), int'(px[i]), mon_e[i].x);
                    chk($sformatf("sb_y%0d", i), int'(py[i]), mon_e[i].y);
                    chk($sformatf("sb_pose%0d", i), int'(ps[i]), mon_e[i].pose);
                    chk($sformatf("sb_face%0d", i), int'(fl[i]), int'(mon_e[i].fl));
                    chk($sformatf("sb_air%0d", i), int'(air[i]), (mon_e[i].pose >= 4) ? 1 : 0);
                end
            end
        end else if (mt[1] || mt[2]) begin
            chk("tick_skew", 1, 0);
        end
    end

    initial begin
        logic [6:0] c;

        // Idle after reset
        do_reset();
        repeat (10) tick(7'h00);
        chk("idle_x", int'(px[0]), 300);
        chk("idle_y", int'(py[0]), 300);

        // Walk right, then left+right together
        repeat (3) tick(7'h04);
        chk("walk_x", int'(px[0]), 306);
        chk("walk_pose", int'(ps[0]), 1);
        chk("walk_face", int'(fl[0]), 0);
        repeat (2) tick(7'h06);
        chk("lr_x", int'(px[0]), 306);
        chk("lr_pose", int'(ps[0]), 0);

        // Left clamp from x=3 on instance 1
        do_reset();
        tick(7'h02);
        chk("clamp_x1", int'(px[1]), 1);
        tick(7'h02);
        chk("clamp_x0", int'(px[1]), 0);
        tick(7'h02);
        chk("clamp_hold", int'(px[1]), 0);
        chk("clamp_pose", int'(ps[1]), 1);

        // Full jump arc; instance 2 clamps at the top of the screen
        do_reset();
        tick(7'h08);
        chk("jump_t0_y", int'(py[0]), 300);
        chk("jump_t0_air", int'(air[0]), 1);
        for (int t = 1; t <= 24; t++) begin
            tick(7'h00);
            if (t == 1)  chk("jump_t1_y", int'(py[0]), 288);
            if (t == 3) begin
                chk("yclamp_y", int'(py[2]), 20);
                chk("yclamp_pose", int'(ps[2]), 5);
            end
            if (t == 11) begin
                chk("yclamp_land_y", int'(py[2]), 50);
                chk("yclamp_land_pose", int'(ps[2]), 0);
            end
            if (t == 12) begin
                chk("apex_y", int'(py[0]), 222);
                chk("apex_pose", int'(ps[0]), 5);
            end
            if (t < 24) chk($sformatf("jump_air_t%0d", t), int'(air[0]), 1);
        end
        chk("land_y", int'(py[0]), 300);
        chk("land_pose", int'(ps[0]), 0);
        chk("land_air", int'(air[0]), 0);

        // Air steering, then reset mid-jump
        do_reset();
        tick(7'h0C);
        chk("air_t0_x", int'(px[0]), 300);
        repeat (4) tick(7'h02);
`ifdef PLAYER_AIR_CONTROL_EN
        chk("air_ctl_x", int'(px[0]), 292);
        chk("air_ctl_face", int'(fl[0]), 1);
`else
        chk("air_ctl_x", int'(px[0]), 308);
        chk("air_ctl_face", int'(fl[0]), 0);
`endif
        do_reset();

        // Randomised play with occasional resets
        for (int k = 0; k < 300; k++) begin
            c    = 7'($urandom);
            c[3] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            tick(c);
        end

        slot();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
